ws2811_frame_sequencer: RTL and testbench
=========================================

# ws2811_frame_sequencer

Frame-level controller behind the ws2811 physical-layer decoder. Consumes the decoder's demodulated bit, bit clock and session-active outputs; assembles this satellite's first NUM_BYTES bytes of each frame into a parallel word; hands it to the register/IO side over a valid/ack handshake; then switches the chain to pass-through for the rest of the frame so downstream satellites receive their data.

## Interface
Parameters:
- NUM_BYTES, 3, payload bytes captured per frame for this satellite (1..16)

Ports:
- masterClk  in  1  master clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- bitIn  in  1  decoded data bit from decoder dataOut
- bitClk  in  1  decoder dataClk; a rising edge marks bitIn valid
- active  in  1  decoder session-active; low = line in reset/idle
- rxAck  in  1  consumer acknowledge; clears rxValid
- rxData  out  8*NUM_BYTES  captured payload; first received byte in MSBs, MSB-first within byte
- rxValid  out  1  rxData holds an unacknowledged frame
- overrun  out  1  a completed frame was dropped while rxValid was high
- frameErr  out  1  one-cycle pulse: frame ended before NUM_BYTES complete
- passThrough  out  1  high while the remainder of the current frame belongs downstream
- fwdBitCnt  out  16  bits forwarded downstream in current/last frame

## Operation
- Edge detect: bitClk and active are registered once; bitEdge = bitClk & !bitClkQ; actFall = !active & activeQ. A bit counts only if bitEdge and active are both high in the same cycle.
- States: IDLE, CAPTURE, FORWARD, SKIP.
- IDLE: passThrough=0. On active rise go to CAPTURE; clear shift register, bitCnt (3b), byteCnt.
- CAPTURE: on each counted bit, shift bitIn into the LSB of the shift register; bitCnt wraps 7->0 and increments byteCnt. On the bit completing byte NUM_BYTES-1: publish, go to FORWARD. On actFall with bits captured < 8*NUM_BYTES (including zero): frameErr pulse, discard shift register, go to IDLE.
- Publish: if rxValid=0 or rxAck=1 in the same cycle, load rxData and set rxValid=1 (net); otherwise keep old rxData, set overrun=1.
- FORWARD: passThrough=1; each counted bit increments fwdBitCnt (saturates at 0xFFFF). actFall -> IDLE (passThrough drops; fwdBitCnt holds until next frame start).
- SKIP: entered from reset when active=1 at reset release; passThrough=0, no capture; actFall -> IDLE.
- rxAck with rxValid=1 clears rxValid and overrun next cycle; rxAck with rxValid=0 is ignored.
- rst mid-frame: all state cleared, rxValid dropped, pending frame lost; next capture waits for a full idle period (via SKIP).

## Timing
- Reset values: rxData=0, rxValid=0, overrun=0, frameErr=0, passThrough=0, fwdBitCnt=0, state IDLE (or SKIP next cycle if active=1).
- Input registration adds 1 cycle: a bitClk rise at cycle n is counted at edge n+1.
- rxValid rises 1 cycle after the final payload bit is counted; passThrough rises the same cycle.
- frameErr pulses 1 cycle after active falls (registered actFall).
- Bit edge and active low in same cycle: bit ignored. Active rising and falling within a frame with no bits: frameErr pulse.
- Bit rate 800 kbps; masterClk >30 MHz gives ≥37 cycles per bit; no back-to-back bit edges occur.

## Configuration
- WS2811_FWD_BIT_CNT_EN defined: fwdBitCnt counter implemented as above.
- Not defined: counter omitted; fwdBitCnt tied to 0; all other behaviour unchanged.

## Test plan
- NUM_BYTES=3, frame 0xA5,0x3C,0xFF then 16 extra bits -> rxData=0xA53CFF, rxValid=1 one cycle after bit 24, passThrough=1 for bits 25-40, fwdBitCnt=16 after active falls.
- Frame of only 12 bits then 25 µs low -> frameErr single pulse, rxValid stays 0, passThrough never asserts.
- Two full frames, no rxAck -> rxData keeps first frame, overrun=1; rxAck -> rxValid=0, overrun=0 next cycle.
- rxAck asserted in the exact publish cycle of frame 2 -> rxData=frame 2, rxValid stays 1, overrun=0.
- rst pulsed at bit 10 with active high -> outputs at reset values, SKIP until active falls; next frame 0x010203 captured correctly.
- Macro undefined, frame with 40 extra bits -> fwdBitCnt=0, rxData/passThrough identical to macro-defined run.

Source files
------------

// File: rtl/ws2811_frame_sequencer.sv
// ws2811_frame_sequencer: frame-level controller behind the ws2811 decoder.
// Captures the first NUM_BYTES bytes of each frame, publishes them over a
// valid/ack handshake, then passes the rest of the frame downstream.
// Optional macro WS2811_FWD_BIT_CNT_EN: implements the forwarded-bit counter;
// when undefined fwdBitCnt is tied to zero.
module ws2811_frame_sequencer #(
  parameter int unsigned NUM_BYTES = 3
) (
  input  logic                   masterClk,
  input  logic                   rst,
  input  logic                   bitIn,
  input  logic                   bitClk,
  input  logic                   active,
  input  logic                   rxAck,
  output logic [8*NUM_BYTES-1:0] rxData,
  output logic                   rxValid,
  output logic                   overrun,
  output logic                   frameErr,
  output logic                   passThrough,
  output logic [15:0]            fwdBitCnt
);

  localparam int unsigned W = 8 * NUM_BYTES;

  typedef enum logic [1:0] {IDLE, CAPTURE, FORWARD, SKIP} state_t;

  state_t         r_state;
  logic           r_bitClkQ, r_bitClkQQ;
  logic           r_activeQ, r_activeQQ;
  logic           r_bitInQ;
  logic           r_postRst;
  logic [W-1:0]   r_shift;
  logic [2:0]     r_bitCnt;
  logic [4:0]     r_byteCnt;

  logic           w_bitEdge, w_actFall, w_actRise, w_bitTake, w_lastBit;
  logic [W-1:0]   w_shiftNext;

  // Input sampling stage; these flops only mirror the line, so they keep
  // sampling through reset and the FSM sees the true level at release.
  always_ff @(posedge masterClk) begin
    r_bitClkQ  <= bitClk;
    r_bitClkQQ <= r_bitClkQ;
    r_activeQ  <= active;
    r_activeQQ <= r_activeQ;
    r_bitInQ   <= bitIn;
  end

  assign w_bitEdge   = r_bitClkQ & ~r_bitClkQQ;
  assign w_actFall   = ~r_activeQ & r_activeQQ;
  assign w_actRise   = r_activeQ & ~r_activeQQ;
  assign w_bitTake   = w_bitEdge & r_activeQ;
  assign w_lastBit   = (r_bitCnt == 3'd7) && (r_byteCnt == 5'(NUM_BYTES - 1));
  assign w_shiftNext = {r_shift[W-2:0], r_bitInQ};

  // Frame FSM with registered handshake, error and pass-through outputs.
  always_ff @(posedge masterClk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_postRst   <= 1'b1;
      r_shift     <= '0;
      r_bitCnt    <= '0;
      r_byteCnt   <= '0;
      rxData      <= '0;
      rxValid     <= 1'b0;
      overrun     <= 1'b0;
      frameErr    <= 1'b0;
      passThrough <= 1'b0;
    end else begin
      frameErr  <= 1'b0;
      r_postRst <= 1'b0;
      if (rxAck && rxValid) begin
        rxValid <= 1'b0;
        overrun <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          passThrough <= 1'b0;
          // A line already active at reset release is mid-frame: sit it out.
          if (r_postRst) begin
            if (r_activeQ) r_state <= SKIP;
          end else if (w_actRise) begin
            r_state   <= CAPTURE;
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_byteCnt <= '0;
          end
        end
        CAPTURE: begin
          if (w_actFall) begin
            frameErr <= 1'b1;
            r_shift  <= '0;
            r_state  <= IDLE;
          end else if (w_bitTake) begin
            r_shift  <= w_shiftNext;
            r_bitCnt <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) r_byteCnt <= r_byteCnt + 5'd1;
            if (w_lastBit) begin
              // Publish overrides the ack clear above when both land together.
              if (!rxValid || rxAck) begin
                rxData  <= w_shiftNext;
                rxValid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              passThrough <= 1'b1;
              r_state     <= FORWARD;
            end
          end
        end
        FORWARD: begin
          if (w_actFall) begin
            passThrough <= 1'b0;
            r_state     <= IDLE;
          end
        end
        SKIP: begin
          passThrough <= 1'b0;
          if (w_actFall) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef WS2811_FWD_BIT_CNT_EN
  logic [15:0] r_fwdBitCnt;

  // Saturating count of bits passed downstream; cleared at frame start.
  always_ff @(posedge masterClk) begin
    if (rst) begin
      r_fwdBitCnt <= '0;
    end else if (r_state == IDLE && !r_postRst && w_actRise) begin
      r_fwdBitCnt <= '0;
    end else if (r_state == FORWARD && w_bitTake && r_fwdBitCnt != 16'hFFFF) begin
      r_fwdBitCnt <= r_fwdBitCnt + 16'd1;
    end
  end

  assign fwdBitCnt = r_fwdBitCnt;
`else
  assign fwdBitCnt = '0;
`endif

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Self-checking bench for ws2811_frame_sequencer (NUM_BYTES=3).
module tb_ws2811_frame_sequencer;

  logic        masterClk = 1'b0;
  logic        rst = 1'b1;
  logic        bitIn = 1'b0;
  logic        bitClk = 1'b0;
  logic        active = 1'b0;
  logic        rxAck = 1'b0;
  logic [23:0] rxData;
  logic        rxValid, overrun, frameErr, passThrough;
  logic [15:0] fwdBitCnt;

  ws2811_frame_sequencer #(.NUM_BYTES(3)) dut (
    .masterClk  (masterClk),
    .rst        (rst),
    .bitIn      (bitIn),
    .bitClk     (bitClk),
    .active     (active),
    .rxAck      (rxAck),
    .rxData     (rxData),
    .rxValid    (rxValid),
    .overrun    (overrun),
    .frameErr   (frameErr),
    .passThrough(passThrough),
    .fwdBitCnt  (fwdBitCnt)
  );

  always #5 masterClk = ~masterClk;

  typedef struct {
    logic [63:0] data;
    int unsigned nbits;
    logic [23:0] exp_data;
    logic        exp_valid;
    int unsigned exp_err;
    logic [15:0] exp_fwd;
  } vec_t;

  vec_t        vecs[7];
  logic [23:0] sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned err_cycles = 0;
  bit          pt_seen = 1'b0;
  logic        prev_valid = 1'b0;
  logic [23:0] prev_data = '0;

  task automatic tick();
    @(negedge masterClk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fwd_exp(input logic [15:0] v);
`ifdef WS2811_FWD_BIT_CNT_EN
    return v;
`else
    return 16'd0 & v;
`endif
  endfunction

  // One bit cell of 12 cycles; on the final payload bit, check publish latency.
  task automatic send_bit(input logic b, input bit chk_pub, input bit ack_pub);
    bitIn  = b;
    bitClk = 1'b1;
    if (chk_pub) begin
      tick();
      chk("pt_before_publish", passThrough, 0);
      if (ack_pub) rxAck = 1'b1;
      tick();
      rxAck = 1'b0;
      chk("pt_at_publish", passThrough, 1);
      chk("valid_at_publish", rxValid, 1);
      repeat (2) tick();
    end else begin
      repeat (4) tick();
    end
    bitClk = 1'b0;
    repeat (8) tick();
  endtask

  task automatic send_frame(input logic [63:0] data, input int unsigned nbits, input bit ack_pub);
    active = 1'b1;
    repeat (6) tick();
    for (int unsigned i = 0; i < nbits; i++)
      send_bit(data[63-i], i == 23, ack_pub);
    repeat (4) tick();
    chk("pt_end_of_frame", passThrough, (nbits >= 24) ? 1 : 0);
    active = 1'b0;
    repeat (30) tick();
  endtask

  task automatic do_ack();
    rxAck = 1'b1;
    tick();
    rxAck = 1'b0;
    chk("ack_rxValid", rxValid, 0);
    chk("ack_overrun", overrun, 0);
  endtask

  initial begin
    vecs[0] = '{{24'hA53CFF, 16'h5AC3, 24'h0},        40, 24'hA53CFF, 1'b1, 0, 16'd16};
    vecs[1] = '{{24'hA53CFF, 40'h0},                  12, 24'h0,      1'b0, 1, 16'd0};
    vecs[2] = '{64'h0,                                 0, 24'h0,      1'b0, 1, 16'd0};
    vecs[3] = '{{24'h123456, 40'h0},                  24, 24'h123456, 1'b1, 0, 16'd0};
    vecs[4] = '{{24'h00FF55, 40'hDEADBEEF01},         64, 24'h00FF55, 1'b1, 0, 16'd40};
    vecs[5] = '{{24'hFFFFFF, 40'h0},                  23, 24'h0,      1'b0, 1, 16'd0};
    vecs[6] = '{{24'h000000, 40'h8000000000},         25, 24'h000000, 1'b1, 0, 16'd1};

    // Monitor: any newly presented frame is checked against the scoreboard.
    fork
      forever begin
        tick();
        if (frameErr) err_cycles++;
        if (passThrough) pt_seen = 1'b1;
        if (rxValid && (!prev_valid || rxData != prev_data)) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_publish: got rxData %h with no frame expected", rxData);
          end else begin
            chk("sb_rxData", rxData, sb.pop_front());
          end
        end
        prev_valid = rxValid;
        prev_data  = rxData;
      end
    join_none

    // Reset values
    repeat (3) tick();
    chk("rst_rxData", rxData, 0);
    chk("rst_rxValid", rxValid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frameErr", frameErr, 0);
    chk("rst_passThrough", passThrough, 0);
    chk("rst_fwdBitCnt", fwdBitCnt, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Table-driven frames
    for (int unsigned i = 0; i < 7; i++) begin
      err_cycles = 0;
      pt_seen    = 1'b0;
      if (vecs[i].exp_valid) sb.push_back(vecs[i].exp_data);
      send_frame(vecs[i].data, vecs[i].nbits, 1'b0);
      chk($sformatf("v%0d_frameErr_cycles", i), err_cycles, vecs[i].exp_err);
      chk($sformatf("v%0d_rxValid", i), rxValid, vecs[i].exp_valid);
      chk($sformatf("v%0d_pt_seen", i), pt_seen, vecs[i].exp_valid);
      chk($sformatf("v%0d_pt_idle", i), passThrough, 0);
      chk($sformatf("v%0d_fwdBitCnt", i), fwdBitCnt, fwd_exp(vecs[i].exp_fwd));
      if (vecs[i].exp_valid) do_ack();
    end

    // Overrun: second frame dropped while first is unacknowledged
    sb.push_back(24'h111111);
    send_frame({24'h111111, 40'h0}, 24, 1'b0);
    send_frame({24'h222222, 40'h0}, 24, 1'b0);
    chk("ovr_rxData", rxData, 24'h111111);
    chk("ovr_rxValid", rxValid, 1);
    chk("ovr_overrun", overrun, 1);
    do_ack();

    // Ack lands in the publish cycle of the second frame
    sb.push_back(24'h333333);
    send_frame({24'h333333, 40'h0}, 24, 1'b0);
    sb.push_back(24'h444444);
    send_frame({24'h444444, 40'h0}, 24, 1'b1);
    chk("ackpub_rxData", rxData, 24'h444444);
    chk("ackpub_rxValid", rxValid, 1);
    chk("ackpub_overrun", overrun, 0);
    do_ack();

    // Reset mid-frame with a pending frame, then SKIP until active falls
    sb.push_back(24'h0A0B0C);
    send_frame({24'h0A0B0C, 8'hFF, 32'h0}, 32, 1'b0);
    active = 1'b1;
    repeat (6) tick();
    for (int unsigned i = 0; i < 10; i++) send_bit(i[0], 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("mrst_rxValid", rxValid, 0);
    chk("mrst_rxData", rxData, 0);
    chk("mrst_overrun", overrun, 0);
    chk("mrst_passThrough", passThrough, 0);
    chk("mrst_fwdBitCnt", fwdBitCnt, 0);
    err_cycles = 0;
    pt_seen    = 1'b0;
    for (int unsigned i = 0; i < 30; i++) send_bit(1'b1, 1'b0, 1'b0);
    active = 1'b0;
    repeat (30) tick();
    chk("skip_rxValid", rxValid, 0);
    chk("skip_pt_seen", pt_seen, 0);
    chk("skip_frameErr_cycles", err_cycles, 0);
    sb.push_back(24'h010203);
    send_frame({24'h010203, 8'hF0, 32'h0}, 32, 1'b0);
    chk("post_rst_rxData", rxData, 24'h010203);
    chk("post_rst_fwdBitCnt", fwdBitCnt, fwd_exp(16'd8));
    do_ack();

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
